// File: rtl/axil_read_interconnect.sv
// AXI-Lite read (AR/R) shared-bus interconnect: round-robin masters, address-decoded slaves, one read in flight.
// Optional slave watchdog enabled by defining AXIL_READ_TIMEOUT_EN.
module axil_read_interconnect #(
    parameter int unsigned NUMBER_MASTER  = 4,
    parameter int unsigned NUMBER_SLAVE   = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET =
        {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
        {32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF},
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0]  m_axil_araddr,
    input  logic [NUMBER_MASTER-1:0]                      m_axil_arvalid,
    output logic [NUMBER_MASTER-1:0]                      m_axil_arready,
    output logic [NUMBER_MASTER-1:0][AXI_DATA_WIDTH-1:0]  m_axil_rdata,
    output logic [NUMBER_MASTER-1:0][1:0]                 m_axil_rresp,
    output logic [NUMBER_MASTER-1:0]                      m_axil_rvalid,
    input  logic [NUMBER_MASTER-1:0]                      m_axil_rready,
    output logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    output logic [NUMBER_SLAVE-1:0]                       s_axil_arvalid,
    input  logic [NUMBER_SLAVE-1:0]                       s_axil_arready,
    input  logic [NUMBER_SLAVE-1:0][AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    input  logic [NUMBER_SLAVE-1:0][1:0]                  s_axil_rresp,
    input  logic [NUMBER_SLAVE-1:0]                       s_axil_rvalid,
    output logic [NUMBER_SLAVE-1:0]                       s_axil_rready
);

    localparam int unsigned M_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
    localparam int unsigned S_W = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    if (NUMBER_MASTER < 1 || NUMBER_SLAVE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axil_read_interconnect: NUMBER_MASTER, NUMBER_SLAVE and TIMEOUT_CYCLES must be >= 1");
    end

    // GRANT is the cycle in which the registered m_axil_arready pulse is visible.
    typedef enum logic [2:0] {IDLE, GRANT, ADDR, RESP, RET} state_e;

    state_e                    state_q, state_d;
    logic [M_W-1:0]            grant_q, grant_d;
    logic [M_W-1:0]            ptr_q, ptr_d;
    logic [S_W-1:0]            sel_q, sel_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      found_c;
    logic                      hit_c;
    logic                      timeout_c;
    int unsigned               idx_c;

    logic [NUMBER_MASTER-1:0]                     m_arready_q, m_arready_d;
    logic [NUMBER_MASTER-1:0]                     m_rvalid_q, m_rvalid_d;
    logic [NUMBER_MASTER-1:0][AXI_DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic [NUMBER_MASTER-1:0][1:0]                m_rresp_q, m_rresp_d;
    logic [NUMBER_SLAVE-1:0]                      s_arvalid_q, s_arvalid_d;
    logic [NUMBER_SLAVE-1:0]                      s_rready_q, s_rready_d;
    logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0]  s_araddr_q, s_araddr_d;

`ifdef AXIL_READ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign timeout_c = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current ADDR/RESP state; restarts on every state change.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && (state_q == ADDR || state_q == RESP)) begin
            cnt_d = TO_W'(cnt_q + 1'b1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state: arbitration, decode, slave handshakes, response return.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        found_c = 1'b0;
        hit_c   = 1'b0;
        idx_c   = 0;
        case (state_q)
            IDLE: begin
                for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
                    idx_c = (32'(ptr_q) + i) % NUMBER_MASTER;
                    if (!found_c && m_axil_arvalid[M_W'(idx_c)]) begin
                        found_c = 1'b1;
                        grant_d = M_W'(idx_c);
                    end
                end
                if (found_c) state_d = GRANT;
            end
            GRANT: begin
                if (m_axil_arvalid[grant_q]) begin
                    addr_d = m_axil_araddr[grant_q];
                    for (int unsigned j = 0; j < NUMBER_SLAVE; j++) begin
                        if (!hit_c && addr_d >= AXI_ADDR_OFFSET[j]
                            && (addr_d - AXI_ADDR_OFFSET[j]) <= AXI_ADDR_RANGE[j]) begin
                            hit_c = 1'b1;
                            sel_d = S_W'(j);
                        end
                    end
                    if (hit_c) begin
                        state_d = ADDR;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                        state_d = RET;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (s_axil_arready[sel_q]) begin
                    state_d = RESP;
                end else if (timeout_c) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = RET;
                end
            end
            RESP: begin
                if (s_axil_rvalid[sel_q]) begin
                    rdata_d = s_axil_rdata[sel_q];
                    rresp_d = s_axil_rresp[sel_q];
                    state_d = RET;
                end else if (timeout_c) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = RET;
                end
            end
            RET: begin
                if (m_axil_rready[grant_q]) begin
                    ptr_d   = (grant_q == M_W'(NUMBER_MASTER - 1)) ? '0 : M_W'(grant_q + 1'b1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port outputs follow the next state so they are registered yet aligned with it.
    always_comb begin
        m_arready_d = '0;
        m_rvalid_d  = '0;
        m_rdata_d   = '0;
        m_rresp_d   = '0;
        s_arvalid_d = '0;
        s_rready_d  = '0;
        s_araddr_d  = '0;
        case (state_d)
            GRANT: m_arready_d[grant_d] = 1'b1;
            ADDR: begin
                s_arvalid_d[sel_d] = 1'b1;
                s_araddr_d[sel_d]  = addr_d;
            end
            RESP: s_rready_d[sel_d] = 1'b1;
            RET: begin
                m_rvalid_d[grant_d] = 1'b1;
                m_rdata_d[grant_d]  = rdata_d;
                m_rresp_d[grant_d]  = rresp_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            m_arready_q <= '0;
            m_rvalid_q  <= '0;
            m_rdata_q   <= '0;
            m_rresp_q   <= '0;
            s_arvalid_q <= '0;
            s_rready_q  <= '0;
            s_araddr_q  <= '0;
`ifdef AXIL_READ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            m_arready_q <= m_arready_d;
            m_rvalid_q  <= m_rvalid_d;
            m_rdata_q   <= m_rdata_d;
            m_rresp_q   <= m_rresp_d;
            s_arvalid_q <= s_arvalid_d;
            s_rready_q  <= s_rready_d;
            s_araddr_q  <= s_araddr_d;
`ifdef AXIL_READ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign m_axil_arready = m_arready_q;
    assign m_axil_rvalid  = m_rvalid_q;
    assign m_axil_rdata   = m_rdata_q;
    assign m_axil_rresp   = m_rresp_q;
    assign s_axil_arvalid = s_arvalid_q;
    assign s_axil_rready  = s_rready_q;
    assign s_axil_araddr  = s_araddr_q;

endmodule

// File: tb/tb_axil_read_interconnect.sv
// Directed bench for axil_read_interconnect; set AXIL_READ_TIMEOUT_EN to also cover the watchdog.
module tb_axil_read_interconnect;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam logic [NM-1:0] ONE_M = 1;
    localparam logic [NS-1:0] ONE_S = 1;

    logic                   aclk = 1'b0;
    logic                   areset;
    logic [NM-1:0][AW-1:0]  m_axil_araddr;
    logic [NM-1:0]          m_axil_arvalid;
    logic [NM-1:0]          m_axil_arready;
    logic [NM-1:0][DW-1:0]  m_axil_rdata;
    logic [NM-1:0][1:0]     m_axil_rresp;
    logic [NM-1:0]          m_axil_rvalid;
    logic [NM-1:0]          m_axil_rready;
    logic [NS-1:0][AW-1:0]  s_axil_araddr;
    logic [NS-1:0]          s_axil_arvalid;
    logic [NS-1:0]          s_axil_arready;
    logic [NS-1:0][DW-1:0]  s_axil_rdata;
    logic [NS-1:0][1:0]     s_axil_rresp;
    logic [NS-1:0]          s_axil_rvalid;
    logic [NS-1:0]          s_axil_rready;

    int errors = 0;
    int checks = 0;

    axil_read_interconnect #(
        .NUMBER_MASTER (NM),
        .NUMBER_SLAVE  (NS),
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arready"}, 64'(m_axil_arready), 64'(0));
        chk({tag, "_rvalid"},  64'(m_axil_rvalid),  64'(0));
        chk({tag, "_s_arvalid"}, 64'(s_axil_arvalid), 64'(0));
        chk({tag, "_s_rready"},  64'(s_axil_rready),  64'(0));
        chk({tag, "_s_araddr"},  64'(s_axil_araddr == '0), 64'(1));
        chk({tag, "_m_rdata"},   64'(m_axil_rdata == '0),  64'(1));
        chk({tag, "_m_rresp"},   64'(m_axil_rresp == '0),  64'(1));
    endtask

    // Walks one read from AR grant to R handshake; si < 0 means the address is unmapped.
    task automatic serve(input int mi, input int si, input logic [31:0] addr,
                         input int arw, input int rw, input int mw,
                         input logic [31:0] data, input logic [1:0] resp, input bit drop);
        int n = 0;
        while (m_axil_arready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("ar_grant", 64'(m_axil_arready), 64'(ONE_M << mi));
        chk("ar_no_slave_yet", 64'(s_axil_arvalid), 64'(0));
        tick();
        if (drop) m_axil_arvalid[mi] = 1'b0;
        chk("arready_pulse", 64'(m_axil_arready), 64'(0));
        if (si >= 0) begin
            for (int k = 0; k <= arw; k++) begin
                chk("s_arvalid", 64'(s_axil_arvalid), 64'(ONE_S << si));
                chk("s_araddr", 64'(s_axil_araddr[si]), 64'(addr));
                if (k < arw) tick();
            end
            s_axil_arready[si] = 1'b1;
            tick();
            s_axil_arready[si] = 1'b0;
            chk("s_arvalid_drop", 64'(s_axil_arvalid), 64'(0));
            for (int k = 0; k <= rw; k++) begin
                chk("s_rready", 64'(s_axil_rready), 64'(ONE_S << si));
                chk("m_rvalid_early", 64'(m_axil_rvalid), 64'(0));
                if (k < rw) tick();
            end
            s_axil_rvalid[si] = 1'b1;
            s_axil_rdata[si]  = data;
            s_axil_rresp[si]  = resp;
            tick();
            s_axil_rvalid[si] = 1'b0;
            s_axil_rdata[si]  = 32'hBAD0_0BAD;
            s_axil_rresp[si]  = 2'b01;
            chk("s_rready_drop", 64'(s_axil_rready), 64'(0));
        end
        for (int k = 0; k <= mw; k++) begin
            chk("m_rvalid", 64'(m_axil_rvalid), 64'(ONE_M << mi));
            chk("m_rdata", 64'(m_axil_rdata[mi]), 64'(data));
            chk("m_rresp", 64'(m_axil_rresp[mi]), 64'(resp));
            chk("ret_no_slave", 64'({s_axil_arvalid, s_axil_rready}), 64'(0));
            if (k < mw) tick();
        end
        m_axil_rready[mi] = 1'b1;
        tick();
        m_axil_rready[mi] = 1'b0;
        chk("m_rvalid_drop", 64'(m_axil_rvalid), 64'(0));
    endtask

    initial begin
        int n;
        areset         = 1'b1;
        m_axil_araddr  = '0;
        m_axil_arvalid = '0;
        m_axil_rready  = '0;
        s_axil_arready = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;
        s_axil_rvalid  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        areset = 1'b0;
        tick();

        // Single read, zero-wait slave 1: exact 3-cycle AR-to-R latency is enforced by serve.
        m_axil_araddr[0]  = 32'h2000_0010;
        m_axil_arvalid[0] = 1'b1;
        serve(0, 1, 32'h2000_0010, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b1);

        // Unmapped address answered locally with DECERR.
        m_axil_araddr[2]  = 32'h5000_0000;
        m_axil_arvalid[2] = 1'b1;
        serve(2, -1, 32'h5000_0000, 0, 0, 0, 32'h0, 2'b11, 1'b1);

        // Backpressure on every handshake; SLVERR from slave passed through.
        m_axil_araddr[1]  = 32'h3000_0004;
        m_axil_arvalid[1] = 1'b1;
        serve(1, 2, 32'h3000_0004, 5, 4, 3, 32'hCAFE_F00D, 2'b10, 1'b1);

        // Reset while waiting in RESP aborts the read.
        m_axil_araddr[3]  = 32'h3000_0000;
        m_axil_arvalid[3] = 1'b1;
        n = 0;
        while (m_axil_arready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_grant", 64'(m_axil_arready), 64'(4'b1000));
        tick();
        m_axil_arvalid[3] = 1'b0;
        chk("rst_s_arvalid", 64'(s_axil_arvalid), 64'(4'b0100));
        s_axil_arready[2] = 1'b1;
        tick();
        s_axil_arready[2] = 1'b0;
        chk("rst_s_rready", 64'(s_axil_rready), 64'(4'b0100));
        tick();
        areset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        tick();
        areset = 1'b0;
        tick();
        chk("rst_no_resp", 64'(m_axil_rvalid), 64'(0));

        // Contention 0 vs 3; pointer restarted at 0 so order is 0,3,0,3.
        m_axil_araddr[0]  = 32'h1000_0100;
        m_axil_araddr[3]  = 32'h4000_0200;
        m_axil_arvalid[0] = 1'b1;
        m_axil_arvalid[3] = 1'b1;
        serve(0, 0, 32'h1000_0100, 0, 0, 0, 32'h1111_0000, 2'b00, 1'b0);
        serve(3, 3, 32'h4000_0200, 0, 1, 0, 32'h3333_0003, 2'b00, 1'b0);
        serve(0, 0, 32'h1000_0100, 1, 0, 0, 32'h1111_0001, 2'b00, 1'b1);
        serve(3, 3, 32'h4000_0200, 0, 0, 1, 32'h3333_0004, 2'b00, 1'b1);
        tick();
        chk("idle_after_contention", 64'({m_axil_arready, s_axil_arvalid}), 64'(0));

`ifdef AXIL_READ_TIMEOUT_EN
        // Slave 3 never responds; watchdog returns SLVERR.
        m_axil_araddr[1]  = 32'h4000_0010;
        m_axil_arvalid[1] = 1'b1;
        n = 0;
        while (m_axil_arready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("to_grant", 64'(m_axil_arready), 64'(4'b0010));
        tick();
        m_axil_arvalid[1] = 1'b0;
        s_axil_arready[3] = 1'b1;
        tick();
        s_axil_arready[3] = 1'b0;
        chk("to_s_rready", 64'(s_axil_rready), 64'(4'b1000));
        n = 0;
        while (m_axil_rvalid == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_m_rvalid", 64'(m_axil_rvalid), 64'(4'b0010));
        chk("to_m_rresp", 64'(m_axil_rresp[1]), 64'(2'b10));
        chk("to_m_rdata", 64'(m_axil_rdata[1]), 64'(0));
        chk("to_s_rready_low", 64'(s_axil_rready), 64'(0));
        s_axil_rvalid[3] = 1'b1;
        m_axil_rready[1] = 1'b1;
        tick();
        m_axil_rready[1] = 1'b0;
        chk("to_late_ignored", 64'({s_axil_rready, m_axil_rvalid}), 64'(0));
        s_axil_rvalid[3] = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
